// File: rtl/life_engine_if.sv
// life_engine_if: control, status and display-read signals of the Game of Life engine.
// Latency: none; plain wires between the sequencer/colour stage and the engine.
// Backpressure: none; requests are single-cycle pulses, status is level.
interface life_engine_if;
  logic        frame_pulse;
  logic        run;
  logic        step;
  logic        reseed;
  logic [7:0]  rd_index;
  logic        rd_alive;
  logic        busy;
  logic [15:0] gen_count;
  logic [8:0]  pop_count;
  logic        overrun;

  modport master (
    output frame_pulse, run, step, reseed, rd_index,
    input  rd_alive, busy, gen_count, pop_count, overrun
  );

  modport slave (
    input  frame_pulse, run, step, reseed, rd_index,
    output rd_alive, busy, gen_count, pop_count, overrun
  );
endinterface

// File: rtl/life_engine.sv
// life_engine: 16x16 toroidal Game of Life grid, serial next-gen into a shadow buffer, atomic commit.
// Latency: rd_alive is combinational; a new generation shows 258 edges after the request edge.
// Backpressure: none; requests while a generation is pending or in flight are dropped and set overrun.
module life_engine #(
  parameter logic [255:0] SEED      = 256'h7_0004_0002,
  parameter int unsigned  FRAME_DIV = 8
) (
  input logic          clk,
  input logic          rst_n,
  life_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  function automatic logic [8:0] popcnt(input logic [255:0] g);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < 256; i++) c = c + {8'd0, g[i]};
    return c;
  endfunction

  localparam logic [8:0] SEED_POP = popcnt(SEED);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  state_t       state_q;
  logic [255:0] cur_q, nxt_q;
  logic [7:0]   idx_q, div_q;
  logic [8:0]   popacc_q, pop_q;
  logic [15:0]  gen_q;
  logic         busy_q, ovr_q, req_q;

  logic [3:0]   x_d, y_d, xm_d, xp_d, ym_d, yp_d, nsum_d;
  logic         nxt_bit_d, div_tick_d, gen_req_d, accept_d;

  // Neighbour sum of cur[idx] with wrap-around on both axes, and the resulting next-state bit.
  always_comb begin
    x_d  = idx_q[3:0];
    y_d  = idx_q[7:4];
    xm_d = x_d - 4'd1;
    xp_d = x_d + 4'd1;
    ym_d = y_d - 4'd1;
    yp_d = y_d + 4'd1;
    nsum_d = {3'd0, cur_q[{ym_d, xm_d}]} + {3'd0, cur_q[{ym_d, x_d}]} + {3'd0, cur_q[{ym_d, xp_d}]}
           + {3'd0, cur_q[{y_d,  xm_d}]}                               + {3'd0, cur_q[{y_d,  xp_d}]}
           + {3'd0, cur_q[{yp_d, xm_d}]} + {3'd0, cur_q[{yp_d, x_d}]} + {3'd0, cur_q[{yp_d, xp_d}]};
    nxt_bit_d = (nsum_d == 4'd3) | (cur_q[idx_q] & (nsum_d == 4'd2));
  end

  // Generation request from the frame divider (run=1) or a step pulse (run=0); accepted only when fully idle.
  always_comb begin
    div_tick_d = bus.run & bus.frame_pulse & (div_q == DIV_LAST);
    gen_req_d  = div_tick_d | (~bus.run & bus.step);
    accept_d   = gen_req_d & (state_q == IDLE) & ~req_q;
  end

  // Engine FSM: reseed overrides everything; otherwise divider, request latch, compute sweep and commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_q    <= SEED;
      nxt_q    <= '0;
      idx_q    <= '0;
      div_q    <= '0;
      popacc_q <= '0;
      pop_q    <= SEED_POP;
      gen_q    <= '0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      req_q    <= 1'b0;
    end else if (bus.reseed) begin
      state_q  <= IDLE;
      cur_q    <= SEED;
      idx_q    <= '0;
      div_q    <= '0;
      popacc_q <= '0;
      pop_q    <= SEED_POP;
      gen_q    <= '0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      // The divider keeps counting while busy so frame cadence is not disturbed by a slow generation.
      if (!bus.run) begin
        div_q <= '0;
      end else if (bus.frame_pulse) begin
        div_q <= div_tick_d ? 8'd0 : div_q + 8'd1;
      end
      if (gen_req_d && !accept_d) ovr_q <= 1'b1;
      if (accept_d) req_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (req_q) begin
            state_q  <= COMPUTE;
            idx_q    <= '0;
            popacc_q <= '0;
            busy_q   <= 1'b1;
            req_q    <= 1'b0;
          end
        end
        COMPUTE: begin
          nxt_q[idx_q] <= nxt_bit_d;
          popacc_q     <= popacc_q + {8'd0, nxt_bit_d};
          idx_q        <= idx_q + 8'd1;
          if (idx_q == 8'd255) state_q <= COMMIT;
        end
        COMMIT: begin
          cur_q   <= nxt_q;
          pop_q   <= popacc_q;
          gen_q   <= gen_q + 16'd1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_alive  = cur_q[bus.rd_index];
  assign bus.busy      = busy_q;
  assign bus.gen_count = gen_q;
  assign bus.pop_count = pop_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: four engine instances (glider/div1, blinker, seam block, glider/div8) under directed scenarios.
// Expected grids come from a reference Life model and are queued on request, checked on completion.
// All waits are cycle-bounded; the summary line reports total and failed comparisons.
module tb_life_engine;
  localparam logic [255:0] SEED_G = 256'h7_0004_0002;
  localparam logic [255:0] SEED_B = (256'd1 << 84) | (256'd1 << 85) | (256'd1 << 86);
  localparam logic [255:0] SEED_W = (256'd1 << 0) | (256'd1 << 15) | (256'd1 << 240) | (256'd1 << 255);
  localparam logic [255:0] BLK_V  = (256'd1 << 69) | (256'd1 << 85) | (256'd1 << 101);
  localparam logic [255:0] SEEDS [4] = '{SEED_G, SEED_B, SEED_W, SEED_G};
  localparam int           DIVS  [4] = '{1, 8, 8, 8};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #300 clk = ~clk;

  logic        step_s [4];
  logic        fp_s   [4];
  logic        run_s  [4];
  logic        rs_s   [4];
  logic [7:0]  rd_idx;
  logic        busy_o [4];
  logic        alive_o[4];
  logic        ovr_o  [4];
  logic [15:0] gen_o  [4];
  logic [8:0]  pop_o  [4];

  life_engine_if ifs [4] ();

  for (genvar k = 0; k < 4; k++) begin : g_dut
    assign ifs[k].step        = step_s[k];
    assign ifs[k].frame_pulse = fp_s[k];
    assign ifs[k].run         = run_s[k];
    assign ifs[k].reseed      = rs_s[k];
    assign ifs[k].rd_index    = rd_idx;
    assign busy_o[k]  = ifs[k].busy;
    assign alive_o[k] = ifs[k].rd_alive;
    assign ovr_o[k]   = ifs[k].overrun;
    assign gen_o[k]   = ifs[k].gen_count;
    assign pop_o[k]   = ifs[k].pop_count;
    life_engine #(.SEED(SEEDS[k]), .FRAME_DIV(DIVS[k])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifs[k])
    );
  end

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [255:0] grid;
    logic [15:0]  gen;
    logic [8:0]   pop;
  } exp_t;
  exp_t         sb[$];
  logic [255:0] mgrid[4];
  logic [15:0]  mgen[4];

  function automatic logic [255:0] life_next(input logic [255:0] g);
    logic [255:0] r;
    int n;
    r = '0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0) n += int'(g[((y + dy + 16) % 16) * 16 + (x + dx + 16) % 16]);
        r[y * 16 + x] = (n == 3) || (g[y * 16 + x] && n == 2);
      end
    end
    return r;
  endfunction

  task automatic push_expect(input int k);
    mgrid[k] = life_next(mgrid[k]);
    mgen[k]  = mgen[k] + 16'd1;
    sb.push_back('{mgrid[k], mgen[k], 9'($countones(mgrid[k]))});
  endtask

  task automatic read_grid(input int k, output logic [255:0] g);
    for (int i = 0; i < 256; i++) begin
      rd_idx = 8'(i);
      #1;
      g[i] = alive_o[k];
    end
  endtask

  // which: 0 = step, 1 = frame_pulse, 2 = reseed. Returns at the negedge after the sampling edge.
  task automatic pulse(input int k, input int which);
    @(negedge clk);
    case (which)
      0:       step_s[k] = 1'b1;
      1:       fp_s[k]   = 1'b1;
      default: rs_s[k]   = 1'b1;
    endcase
    @(negedge clk);
    step_s[k] = 1'b0;
    fp_s[k]   = 1'b0;
    rs_s[k]   = 1'b0;
  endtask

  task automatic wait_done(input int k, input int probe, output int hi, output int flip, output bit ok);
    logic p0, p;
    hi = 0; flip = -1; ok = 1'b0;
    rd_idx = 8'(probe);
    #1;
    p0 = alive_o[k];
    for (int i = 1; i <= 600 && !ok; i++) begin
      @(negedge clk);
      rd_idx = 8'(probe);
      #1;
      p = alive_o[k];
      if (flip < 0 && p !== p0) flip = i;
      if (busy_o[k]) hi++;
      else if (hi > 0) ok = 1'b1;
    end
  endtask

  task automatic pop_obs(input int k, output exp_t e, output logic [255:0] g, output bit have);
    have = (sb.size() != 0);
    if (have) e = sb.pop_front();
    else e = '{default: '0};
    read_grid(k, g);
  endtask

  task automatic test_reset();
    logic [255:0] g;
    read_grid(0, g);
    total++; if (g !== SEED_G) begin bad++; $display("FAIL reset_grid: got %h want %h", g, SEED_G); end
    total++; if (pop_o[0] !== 9'd5) begin bad++; $display("FAIL reset_pop: got %0d want 5", pop_o[0]); end
    total++; if (gen_o[0] !== 16'd0) begin bad++; $display("FAIL reset_gen: got %0d want 0", gen_o[0]); end
    total++; if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o[0]); end
    total++; if (ovr_o[0] !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", ovr_o[0]); end
    total++; if (pop_o[2] !== 9'd4) begin bad++; $display("FAIL reset_pop_wrap: got %0d want 4", pop_o[2]); end
  endtask

  task automatic test_blinker();
    int hi, flip; bit ok, have; exp_t e; logic [255:0] g, want;
    for (int s = 0; s < 2; s++) begin
      want = (s == 0) ? BLK_V : SEED_B;
      push_expect(1);
      pulse(1, 0);
      wait_done(1, 69, hi, flip, ok);
      total++; if (!ok) begin bad++; $display("FAIL blinker_done step%0d: busy hi=%0d, no completion in 600 cycles", s, hi); end
      total++; if (hi != 257) begin bad++; $display("FAIL blinker_busy_cycles: got %0d want 257", hi); end
      total++; if (flip != 258) begin bad++; $display("FAIL blinker_latency: got %0d want 258", flip); end
      pop_obs(1, e, g, have);
      total++; if (!have || g !== e.grid || g !== want) begin bad++; $display("FAIL blinker_grid step%0d: got %h want %h", s, g, want); end
      total++; if (pop_o[1] !== e.pop) begin bad++; $display("FAIL blinker_pop: got %0d want %0d", pop_o[1], e.pop); end
      total++; if (gen_o[1] !== e.gen) begin bad++; $display("FAIL blinker_gen: got %0d want %0d", gen_o[1], e.gen); end
    end
  endtask

  task automatic test_glider();
    int hi, flip; bit ok, have; exp_t e; logic [255:0] g;
    for (int s = 0; s < 4; s++) begin
      push_expect(0);
      pulse(0, 1);
      wait_done(0, 1, hi, flip, ok);
      total++; if (!ok) begin bad++; $display("FAIL glider_done gen%0d: busy hi=%0d, no completion", s + 1, hi); end
      pop_obs(0, e, g, have);
      total++; if (!have || g !== e.grid) begin bad++; $display("FAIL glider_grid gen%0d: got %h want %h", s + 1, g, e.grid); end
      total++; if (pop_o[0] !== e.pop) begin bad++; $display("FAIL glider_pop: got %0d want %0d", pop_o[0], e.pop); end
      total++; if (gen_o[0] !== e.gen) begin bad++; $display("FAIL glider_gen: got %0d want %0d", gen_o[0], e.gen); end
      repeat (740) @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    int hi, flip; bit ok, have; exp_t e; logic [255:0] g;
    for (int s = 0; s < 3; s++) begin
      push_expect(2);
      pulse(2, 0);
      wait_done(2, 0, hi, flip, ok);
      total++; if (!ok) begin bad++; $display("FAIL wrap_done step%0d: no completion", s); end
      pop_obs(2, e, g, have);
      total++; if (!have || g !== e.grid || g !== SEED_W) begin bad++; $display("FAIL wrap_grid step%0d: got %h want %h", s, g, SEED_W); end
      total++; if (pop_o[2] !== 9'd4) begin bad++; $display("FAIL wrap_pop: got %0d want 4", pop_o[2]); end
      total++; if (gen_o[2] !== e.gen) begin bad++; $display("FAIL wrap_gen: got %0d want %0d", gen_o[2], e.gen); end
    end
  endtask

  task automatic test_overrun();
    int hi, flip; bit ok, have; exp_t e; logic [255:0] g;
    pulse(1, 2);
    mgrid[1] = SEED_B;
    mgen[1]  = 16'd0;
    total++; if (gen_o[1] !== 16'd0) begin bad++; $display("FAIL overrun_reseed_gen: got %0d want 0", gen_o[1]); end
    push_expect(1);
    pulse(1, 0);
    repeat (8) @(negedge clk);
    pulse(1, 0);
    total++; if (ovr_o[1] !== 1'b1) begin bad++; $display("FAIL overrun_flag: got %b want 1", ovr_o[1]); end
    wait_done(1, 69, hi, flip, ok);
    total++; if (!ok) begin bad++; $display("FAIL overrun_done: no completion"); end
    pop_obs(1, e, g, have);
    total++; if (!have || g !== e.grid) begin bad++; $display("FAIL overrun_grid: got %h want %h", g, e.grid); end
    total++; if (gen_o[1] !== 16'd1) begin bad++; $display("FAIL overrun_gen: got %0d want 1", gen_o[1]); end
    total++; if (ovr_o[1] !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", ovr_o[1]); end
  endtask

  task automatic test_reseed_mid();
    logic [255:0] g;
    pulse(1, 0);
    repeat (50) @(negedge clk);
    total++; if (busy_o[1] !== 1'b1) begin bad++; $display("FAIL reseed_mid_busy_before: got %b want 1", busy_o[1]); end
    pulse(1, 2);
    mgrid[1] = SEED_B;
    mgen[1]  = 16'd0;
    total++; if (busy_o[1] !== 1'b0) begin bad++; $display("FAIL reseed_mid_busy: got %b want 0", busy_o[1]); end
    total++; if (gen_o[1] !== 16'd0) begin bad++; $display("FAIL reseed_mid_gen: got %0d want 0", gen_o[1]); end
    total++; if (ovr_o[1] !== 1'b0) begin bad++; $display("FAIL reseed_mid_overrun: got %b want 0", ovr_o[1]); end
    read_grid(1, g);
    total++; if (g !== SEED_B) begin bad++; $display("FAIL reseed_mid_grid: got %h want %h", g, SEED_B); end
    repeat (300) @(negedge clk);
    read_grid(1, g);
    total++; if (g !== SEED_B || gen_o[1] !== 16'd0) begin bad++; $display("FAIL reseed_mid_aborted: grid %h gen %0d want %h gen 0", g, gen_o[1], SEED_B); end
  endtask

  task automatic test_priority();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    step_s[1] = 1'b1;
    rs_s[1]   = 1'b1;
    @(negedge clk);
    step_s[1] = 1'b0;
    rs_s[1]   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy_o[1]) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL priority_busy: got busy seen=%b want 0", seen); end
    total++; if (ovr_o[1] !== 1'b0) begin bad++; $display("FAIL priority_overrun: got %b want 0", ovr_o[1]); end
    total++; if (gen_o[1] !== 16'd0) begin bad++; $display("FAIL priority_gen: got %0d want 0", gen_o[1]); end
  endtask

  task automatic test_divider();
    int hi, flip; bit ok, have, seen; exp_t e; logic [255:0] g;
    seen = 1'b0;
    for (int p = 0; p < 7; p++) begin
      pulse(3, 1);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (busy_o[3]) seen = 1'b1;
      end
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL divider_early: busy seen=%b after 7 pulses, want 0", seen); end
    push_expect(3);
    pulse(3, 1);
    @(negedge clk);
    total++; if (busy_o[3] !== 1'b1) begin bad++; $display("FAIL divider_busy: got %b want 1 after 8th pulse", busy_o[3]); end
    wait_done(3, 1, hi, flip, ok);
    total++; if (!ok) begin bad++; $display("FAIL divider_done: no completion"); end
    pop_obs(3, e, g, have);
    total++; if (!have || g !== e.grid) begin bad++; $display("FAIL divider_grid: got %h want %h", g, e.grid); end
    total++; if (gen_o[3] !== 16'd1) begin bad++; $display("FAIL divider_gen: got %0d want 1", gen_o[3]); end
  endtask

  task automatic test_async_reset();
    logic [255:0] g;
    pulse(0, 1);
    repeat (30) @(negedge clk);
    #100;
    rst_n = 1'b0;
    #5;
    total++; if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL async_busy: got %b want 0", busy_o[0]); end
    total++; if (gen_o[0] !== 16'd0) begin bad++; $display("FAIL async_gen: got %0d want 0", gen_o[0]); end
    total++; if (pop_o[0] !== 9'd5) begin bad++; $display("FAIL async_pop: got %0d want 5", pop_o[0]); end
    read_grid(0, g);
    total++; if (g !== SEED_G) begin bad++; $display("FAIL async_grid: got %h want %h", g, SEED_G); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      step_s[k] = 1'b0;
      fp_s[k]   = 1'b0;
      rs_s[k]   = 1'b0;
      run_s[k]  = (k == 0 || k == 3);
      mgrid[k]  = SEEDS[k];
      mgen[k]   = 16'd0;
    end
    rd_idx = 8'd0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_blinker();
    test_glider();
    test_wrap();
    test_overrun();
    test_reseed_mid();
    test_priority();
    test_divider();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
